uart_send_fifo: RTL and testbench
=================================

Name: uart_send_fifo

Overview:
Parametrised successor to the single-byte UART transmitter: configurable data width, parity and stop bits, fronted by a FIFO with a valid/ready write port so producers can burst words without polling busy. It sits between on-chip producers (test sequencers, debug/log engines) and the board TXD pin. Frames are sent back-to-back, with no idle gap while the FIFO holds data.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 115200, baud rate; BAUD_DIV = CLK_FREQ/UART_BPS (integer truncation, must be >= 2)
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even; any other value is an elaboration error
STOP_BITS, 1, stop bits, legal 1 or 2
FIFO_DEPTH, 16, FIFO entries, power of 2, >= 2

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  asynchronous, active-high reset
tx_valid_i  input  1  write request
tx_data_i  input  DATA_BITS  word to send, LSB transmitted first
tx_ready_o  output  1  FIFO can accept a word (= not full)
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO
uart_tx_busy_o  output  1  high while a frame is in flight or the FIFO is non-empty
uart_txd_o  output  1  serial line, registered, idles high

Behaviour:
- Reset, asynchronous and dominant: uart_txd_o=1, tx_ready_o=1, fifo_level_o=0, uart_tx_busy_o=0, FSM=IDLE, FIFO contents discarded. Reset mid-frame drives the line high immediately and truncates the frame.
- Write: the word is accepted on a rising edge when tx_valid_i && tx_ready_o. fifo_level_o increments on that same edge. If tx_ready_o=0, tx_valid_i is ignored and nothing is dropped into the FIFO.
- Simultaneous write and pop: level unchanged. Data written into an empty FIFO is poppable on the next cycle (no fall-through).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO is non-empty, pop into the shift register, compute parity and go to START. uart_txd_o goes 0 on this edge.
  - Latency: a word accepted into an empty FIFO at edge k makes uart_txd_o fall at edge k+1.
- Each bit is held for exactly BAUD_DIV clocks. The baud counter runs 0..BAUD_DIV-1 and resets on every state entry.
- START: line 0. Then DATA: DATA_BITS bits, LSB first, with a bit counter.
- PARITY: entered only if PARITY_MODE != 0.
  - Even mode: parity bit = XOR of data bits.
  - Odd mode: parity bit = inverted XOR of data bits.
- STOP: line 1 for STOP_BITS*BAUD_DIV clocks.
- End of the final stop clock:
  - FIFO non-empty: pop and go straight to START (line falls on that edge, zero idle gap).
  - FIFO empty: go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) * BAUD_DIV clocks.
- uart_tx_busy_o = (state != IDLE) || (fifo_level_o != 0), registered or combinational from registers. It must be high on the edge after a word is accepted.
- tx_data_i bits above DATA_BITS do not exist. The shift register width is DATA_BITS.
- FIFO full: tx_ready_o=0 exactly while fifo_level_o == FIFO_DEPTH. It rises the cycle after a pop.

Decomposition:
- Package uart_pkg: parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), FSM state encoding, and a constant function computing BAUD_DIV and the counter width with elaboration checks.
- One sub-module: uart_sync_fifo.
  - Parameters WIDTH, DEPTH.
  - Ports: wr_en, wr_data, rd_en, rd_data, full, empty, level.
  - Registered read, pointers with extra wrap bit.
- The transmit FSM stays in uart_send_fifo.

Test Plan:
- Defaults (BAUD_DIV=434), write 0x48 once -> txd low 434 clocks, then bits 0,0,0,1,0,0,1,0 (434 each), stop high 434, frame 4340 clocks, busy drops the cycle after stop ends, level back to 0.
- CLK_FREQ=8, UART_BPS=1, write "Hello World!" (12 words) in 12 consecutive cycles -> all accepted (depth 16), frames back-to-back with no extra high cycles between stop and next start, decoded string matches.
- DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2, BAUD_DIV=8:
  - Write 0x48 -> parity bit 0, two stop bits, 88-clock frame.
  - PARITY_MODE=1 -> parity bit 1.
- FIFO_DEPTH=4, BAUD_DIV=8, hold valid 10 cycles -> first word popped after one cycle, 5 accepted total (4 stored + 1 popped), tx_ready_o low once level=4, rises one cycle after next pop, no word lost or duplicated.
- Assert rst_i mid-DATA of second frame with 3 queued -> txd high immediately (asynchronously), level 0, busy 0. A new write after deassert sends a clean full frame.
- Write and pop on the same edge with level=2 -> level stays 2; word order preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fronted UART transmitter: parity mode
// encodings, transmit FSM state encoding, and constant helpers that derive
// the baud divider, size its counter and compute the parity bit.
`timescale 1ns/1ps
package uart_pkg;

    localparam int PAR_NONE      = 0;
    localparam int PAR_ODD       = 1;
    localparam int PAR_EVEN      = 2;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Clocks per bit, truncated; returns 0 for a nonsensical baud rate so the
    // legality check in the top level rejects it.
    function automatic int calc_baud_div(input longint clk_freq, input longint bps);
        if (bps <= 64'sd0) begin
            return 0;
        end else begin
            return int'(clk_freq / bps);
        end
    endfunction

    // Width of a counter that must reach baud_div-1 (at least one bit).
    function automatic int calc_cnt_width(input int baud_div);
        if (baud_div <= 2) begin
            return 1;
        end else begin
            return $clog2(baud_div);
        end
    endfunction

    // True when the frame/FIFO configuration is one the transmitter supports.
    function automatic bit cfg_legal(input int baud_div, input int data_bits,
                                     input int parity_mode, input int stop_bits,
                                     input int fifo_depth);
        bit ok;
        ok = 1'b1;
        if (baud_div < 2) ok = 1'b0;
        if ((data_bits < 5) || (data_bits > MAX_DATA_BITS)) ok = 1'b0;
        if ((parity_mode != PAR_NONE) && (parity_mode != PAR_ODD) &&
            (parity_mode != PAR_EVEN)) ok = 1'b0;
        if ((stop_bits != 1) && (stop_bits != 2)) ok = 1'b0;
        if ((fifo_depth < 2) || ((fifo_depth & (fifo_depth - 1)) != 0)) ok = 1'b0;
        return ok;
    endfunction

    // Parity bit over zero-extended data: even = XOR, odd = inverted XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input int mode);
        if (mode == PAR_ODD) begin
            return ~(^data);
        end else begin
            return ^data;
        end
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered read port. Pointers carry an extra wrap
// bit so full and empty are distinguished without a separate counter.
`timescale 1ns/1ps
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign level   = wr_ptr_r - rd_ptr_r;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign wr_ok_s = wr_en && !full;
    assign rd_ok_s = rd_en && !empty;

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk_i) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Write and read pointers; reset empties the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(32'd1);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(32'd1);
            end
        end
    end

    // Registered read data: the popped word is valid the cycle after rd_en.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data <= {WIDTH{1'b0}};
        end else if (rd_ok_s) begin
            rd_data <= mem_r[rd_ptr_r[AW-1:0]];
        end
    end

endmodule

// File: rtl/uart_send_fifo.sv
// FIFO-fronted UART transmitter. Producers push words over a valid/ready
// port; the FSM pops them and sends frames back-to-back on a registered TXD.
`timescale 1ns/1ps
module uart_send_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int UART_BPS    = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          tx_valid_i,
    input  logic [DATA_BITS-1:0]          tx_data_i,
    output logic                          tx_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          uart_tx_busy_o,
    output logic                          uart_txd_o
);

    localparam int BAUD_DIV = calc_baud_div(longint'(CLK_FREQ), longint'(UART_BPS));
    localparam int CNT_W    = calc_cnt_width(BAUD_DIV);
    localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
    localparam bit               HAS_PARITY = (PARITY_MODE != PAR_NONE);

    if (!cfg_legal(BAUD_DIV, DATA_BITS, PARITY_MODE, STOP_BITS, FIFO_DEPTH)) begin : g_bad_cfg
        $error("uart_send_fifo: illegal parameter combination");
    end

    tx_state_e              state_r;
    tx_state_e              state_next_s;
    logic [CNT_W-1:0]       baud_cnt_r;
    logic [3:0]             bit_cnt_r;
    logic [3:0]             bit_cnt_next_s;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   parity_r;
    logic                   txd_r;
    logic                   txd_next_s;
    logic                   pop_s;
    logic                   shift_en_s;
    logic                   bit_end_s;
    logic                   load_s;
    logic                   wr_en_s;
    logic [DATA_BITS-1:0]   fifo_rd_data_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [LVL_W-1:0]       fifo_level_s;

    assign wr_en_s   = tx_valid_i && !fifo_full_s;
    assign bit_end_s = (baud_cnt_r == BAUD_LAST);
    // The FIFO read is registered, so the popped word lands in the shift
    // register during the first START clock; START always lasts >= 2 clocks.
    assign load_s    = (state_r == ST_START) && (baud_cnt_r == {CNT_W{1'b0}});

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (wr_en_s),
        .wr_data (tx_data_i),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level_s)
    );

    // Next-state, pop request and next line level for the transmit FSM.
    always_comb begin
        state_next_s   = state_r;
        bit_cnt_next_s = bit_cnt_r;
        txd_next_s     = txd_r;
        pop_s          = 1'b0;
        shift_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                txd_next_s = 1'b1;
                if (!fifo_empty_s) begin
                    pop_s          = 1'b1;
                    state_next_s   = ST_START;
                    txd_next_s     = 1'b0;
                    bit_cnt_next_s = 4'd0;
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s   = ST_DATA;
                    txd_next_s     = shift_r[0];
                    bit_cnt_next_s = 4'd0;
                end else begin
                    state_next_s   = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_cnt_r == DATA_LAST) begin
                        bit_cnt_next_s = 4'd0;
                        if (HAS_PARITY) begin
                            state_next_s = ST_PARITY;
                            txd_next_s   = parity_r;
                        end else begin
                            state_next_s = ST_STOP;
                            txd_next_s   = 1'b1;
                        end
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + 4'd1;
                        shift_en_s     = 1'b1;
                        txd_next_s     = shift_r[1];
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_next_s   = ST_STOP;
                    txd_next_s     = 1'b1;
                    bit_cnt_next_s = 4'd0;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    if (bit_cnt_r == STOP_LAST) begin
                        bit_cnt_next_s = 4'd0;
                        if (!fifo_empty_s) begin
                            // Back-to-back: next start bit begins right now.
                            pop_s        = 1'b1;
                            state_next_s = ST_START;
                            txd_next_s   = 1'b0;
                        end else begin
                            state_next_s = ST_IDLE;
                            txd_next_s   = 1'b1;
                        end
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + 4'd1;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                txd_next_s     = 1'b1;
                bit_cnt_next_s = 4'd0;
            end
        endcase
    end

    // FSM state, bit counter and the registered serial line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            txd_r     <= txd_next_s;
        end
    end

    // Baud counter: restarts on every state entry and at every bit boundary.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            baud_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_IDLE) || bit_end_s || (state_next_s != state_r)) begin
            baud_cnt_r <= {CNT_W{1'b0}};
        end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(32'd1);
        end
    end

    // Shift register and parity, loaded from the FIFO read port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_r  <= {DATA_BITS{1'b0}};
            parity_r <= 1'b0;
        end else if (load_s) begin
            shift_r  <= fifo_rd_data_s;
            parity_r <= calc_parity(MAX_DATA_BITS'(fifo_rd_data_s), PARITY_MODE);
        end else if (shift_en_s) begin
            shift_r  <= {1'b0, shift_r[DATA_BITS-1:1]};
        end
    end

    assign tx_ready_o     = !fifo_full_s;
    assign fifo_level_o   = fifo_level_s;
    assign uart_tx_busy_o = (state_r != ST_IDLE) || (fifo_level_s != {LVL_W{1'b0}});
    assign uart_txd_o     = txd_r;

endmodule

// File: tb/tb_uart_send_fifo.sv
// Directed bench for uart_send_fifo: five instances cover the default 8N1
// configuration, a fast 8N1 build, 7E2/7O2 framing and a depth-4 FIFO.
`timescale 1ns/1ps
module tb_uart_send_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // inst 0: defaults (BAUD_DIV 434)
    logic v0 = 1'b0; logic [7:0] d0 = 8'h00; logic ready0, busy0, txd0; logic [4:0] lvl0;
    // inst 1: BAUD_DIV 8, 8N1, depth 16
    logic v1 = 1'b0; logic [7:0] d1 = 8'h00; logic ready1, busy1, txd1; logic [4:0] lvl1;
    // inst 2: 7 data, even parity, 2 stop, BAUD_DIV 8
    logic v2 = 1'b0; logic [6:0] d2 = 7'h00; logic ready2, busy2, txd2; logic [4:0] lvl2;
    // inst 3: 7 data, odd parity, 2 stop, BAUD_DIV 8
    logic v3 = 1'b0; logic [6:0] d3 = 7'h00; logic ready3, busy3, txd3; logic [4:0] lvl3;
    // inst 4: depth 4, BAUD_DIV 8, 8N1
    logic v4 = 1'b0; logic [7:0] d4 = 8'h00; logic ready4, busy4, txd4; logic [2:0] lvl4;

    uart_send_fifo u_def (
        .clk_i(clk), .rst_i(rst), .tx_valid_i(v0), .tx_data_i(d0), .tx_ready_o(ready0),
        .fifo_level_o(lvl0), .uart_tx_busy_o(busy0), .uart_txd_o(txd0));

    uart_send_fifo #(.CLK_FREQ(8), .UART_BPS(1)) u_hw (
        .clk_i(clk), .rst_i(rst), .tx_valid_i(v1), .tx_data_i(d1), .tx_ready_o(ready1),
        .fifo_level_o(lvl1), .uart_tx_busy_o(busy1), .uart_txd_o(txd1));

    uart_send_fifo #(.CLK_FREQ(8), .UART_BPS(1), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_even (
        .clk_i(clk), .rst_i(rst), .tx_valid_i(v2), .tx_data_i(d2), .tx_ready_o(ready2),
        .fifo_level_o(lvl2), .uart_tx_busy_o(busy2), .uart_txd_o(txd2));

    uart_send_fifo #(.CLK_FREQ(8), .UART_BPS(1), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_odd (
        .clk_i(clk), .rst_i(rst), .tx_valid_i(v3), .tx_data_i(d3), .tx_ready_o(ready3),
        .fifo_level_o(lvl3), .uart_tx_busy_o(busy3), .uart_txd_o(txd3));

    uart_send_fifo #(.CLK_FREQ(8), .UART_BPS(1), .FIFO_DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_i(rst), .tx_valid_i(v4), .tx_data_i(d4), .tx_ready_o(ready4),
        .fifo_level_o(lvl4), .uart_tx_busy_o(busy4), .uart_txd_o(txd4));

    logic [7:0] hello [12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                               8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    int exp_lvl4 [10] = '{1, 1, 2, 3, 4, 4, 4, 4, 4, 4};
    logic [7:0] rst_words [5] = '{8'h11, 8'h00, 8'h22, 8'h33, 8'h44};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input int sel);
        case (sel)
            0: return txd0;
            1: return txd1;
            2: return txd2;
            3: return txd3;
            4: return txd4;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drv(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            0: begin v0 = v; d0 = d; end
            1: begin v1 = v; d1 = d; end
            2: begin v2 = v; d2 = d[6:0]; end
            3: begin v3 = v; d3 = d[6:0]; end
            4: begin v4 = v; d4 = d; end
            default: ;
        endcase
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {6'b000000, 1'b1, d, 1'b0};
    endfunction

    // Wait (bounded) for the line to go low, sampling on falling clock edges.
    task automatic wait_fall(input int sel, input int limit);
        int n = 0;
        while ((line(sel) !== 1'b0) && (n < limit)) begin
            @(negedge clk);
            n++;
        end
        check("fall_timeout", line(sel), 0);
    endtask

    // Starting at the first start-bit clock, record nb bits of bd clocks each,
    // checking that the line is stable across every bit period.
    task automatic capture(input int sel, input int bd, input int nb, output logic [15:0] fr);
        logic ref_v;
        logic v;
        logic stable;
        fr = 16'h0000;
        ref_v = 1'b1;
        for (int b = 0; b < nb; b++) begin
            stable = 1'b1;
            for (int c = 0; c < bd; c++) begin
                if ((b != 0) || (c != 0)) @(negedge clk);
                v = line(sel);
                if (c == 0) ref_v = v;
                else if (v !== ref_v) stable = 1'b0;
            end
            fr[b] = ref_v;
            check("bit_stable", stable, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] fr_a;
        logic [15:0] fr_b;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_txd", txd0, 1);
        check("rst_ready", ready0, 1);
        check("rst_level", lvl0, 0);
        check("rst_busy", busy0, 0);
        check("rst_txd_d4", txd4, 1);
        check("rst_level_d4", lvl4, 0);

        // ---------------- default config, single 0x48 ----------------
        drv(0, 1'b1, 8'h48);
        @(negedge clk);
        drv(0, 1'b0, 8'h00);
        check("def_level_after_wr", lvl0, 1);
        check("def_busy_after_wr", busy0, 1);
        check("def_txd_before_pop", txd0, 1);
        @(negedge clk);
        check("def_latency_fall", txd0, 0);
        check("def_level_after_pop", lvl0, 0);
        capture(0, 434, 10, fr_a);
        check("def_frame_0x48", fr_a, 16'h0290);
        check("def_busy_last_stop", busy0, 1);
        @(negedge clk);
        check("def_busy_drop", busy0, 0);
        check("def_idle_txd", txd0, 1);
        check("def_idle_level", lvl0, 0);

        // ---------------- Hello World, back-to-back ----------------
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    check("hello_ready", ready1, 1);
                    drv(1, 1'b1, hello[i]);
                    @(negedge clk);
                end
                drv(1, 1'b0, 8'h00);
                check("hello_level", lvl1, 11);
            end
            begin
                wait_fall(1, 4);
                for (int f = 0; f < 12; f++) begin
                    capture(1, 8, 10, fr_b);
                    check("hello_char", fr_b, frame8(hello[f]));
                    @(negedge clk);
                    if (f < 11) begin
                        check("hello_gap", txd1, 0);
                    end else begin
                        check("hello_idle", txd1, 1);
                        check("hello_busy", busy1, 0);
                    end
                end
            end
        join

        // ---------------- 7E2 and 7O2 ----------------
        drv(2, 1'b1, 8'h48);
        drv(3, 1'b1, 8'h48);
        @(negedge clk);
        drv(2, 1'b0, 8'h00);
        drv(3, 1'b0, 8'h00);
        fork
            begin
                wait_fall(2, 4);
                capture(2, 8, 11, fr_a);
                check("even_frame", fr_a, 16'h0690);
                check("even_busy_last", busy2, 1);
                @(negedge clk);
                check("even_len", busy2, 0);
            end
            begin
                wait_fall(3, 4);
                capture(3, 8, 11, fr_b);
                check("odd_frame", fr_b, 16'h0790);
                check("odd_busy_last", busy3, 1);
                @(negedge clk);
                check("odd_len", busy3, 0);
            end
        join

        // ---------------- depth-4 backpressure ----------------
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    check("d4_ready", ready4, (i < 5) ? 1 : 0);
                    drv(4, 1'b1, 8'hA0 + 8'((i < 5) ? i : 5));
                    @(negedge clk);
                    check("d4_level", lvl4, exp_lvl4[i]);
                end
                drv(4, 1'b0, 8'h00);
            end
            begin
                wait_fall(4, 20);
                capture(4, 8, 10, fr_a);
                check("d4_word0", fr_a, frame8(8'hA0));
                check("d4_full_ready", ready4, 0);
                check("d4_full_level", lvl4, 4);
                @(negedge clk);
                check("d4_ready_rise", ready4, 1);
                check("d4_level_pop", lvl4, 3);
                check("d4_gap0", txd4, 0);
                for (int f = 1; f < 5; f++) begin
                    capture(4, 8, 10, fr_a);
                    check("d4_word", fr_a, frame8(8'hA0 + 8'(f)));
                    @(negedge clk);
                    if (f < 4) begin
                        check("d4_gap", txd4, 0);
                    end else begin
                        check("d4_idle", txd4, 1);
                        check("d4_busy", busy4, 0);
                    end
                end
            end
        join

        // ---------------- write and pop on the same edge ----------------
        drv(1, 1'b1, 8'h3C);
        @(negedge clk);
        drv(1, 1'b0, 8'h00);
        fork
            begin
                wait_fall(1, 4);
                capture(1, 8, 10, fr_a);
                check("sim_wordA", fr_a, frame8(8'h3C));
            end
            begin
                @(negedge clk);
                drv(1, 1'b1, 8'hB1);
                @(negedge clk);
                drv(1, 1'b1, 8'hC2);
                @(negedge clk);
                drv(1, 1'b0, 8'h00);
            end
        join
        check("sim_level_pre", lvl1, 2);
        drv(1, 1'b1, 8'hD3);
        @(negedge clk);
        drv(1, 1'b0, 8'h00);
        check("sim_level_same", lvl1, 2);
        check("sim_start", txd1, 0);
        capture(1, 8, 10, fr_a);
        check("sim_wordB", fr_a, frame8(8'hB1));
        @(negedge clk);
        check("sim_gapB", txd1, 0);
        capture(1, 8, 10, fr_a);
        check("sim_wordC", fr_a, frame8(8'hC2));
        @(negedge clk);
        check("sim_gapC", txd1, 0);
        capture(1, 8, 10, fr_a);
        check("sim_wordD", fr_a, frame8(8'hD3));
        @(negedge clk);
        check("sim_idle", txd1, 1);
        check("sim_busy", busy1, 0);

        // ---------------- asynchronous reset mid-frame ----------------
        for (int i = 0; i < 5; i++) begin
            drv(1, 1'b1, rst_words[i]);
            @(negedge clk);
        end
        drv(1, 1'b0, 8'h00);
        repeat (90) @(negedge clk);
        check("pre_rst_line", txd1, 0);
        check("pre_rst_level", lvl1, 3);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_txd", txd1, 1);
        check("rst_async_level", lvl1, 0);
        check("rst_async_busy", busy1, 0);
        check("rst_async_ready", ready1, 1);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready_even", ready2, 1);
        check("rst_ready_odd", ready3, 1);
        drv(1, 1'b1, 8'h5A);
        @(negedge clk);
        drv(1, 1'b0, 8'h00);
        wait_fall(1, 4);
        capture(1, 8, 10, fr_a);
        check("post_rst_frame", fr_a, frame8(8'h5A));
        @(negedge clk);
        check("post_rst_idle", txd1, 1);
        check("post_rst_busy", busy1, 0);
        check("post_rst_level", lvl1, 0);
        repeat (20) @(negedge clk);
        check("post_rst_no_stale", txd1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
